// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART blocks
// Purpose: parity mode and receiver state enums, NCO increment calculation.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // round(2^width * baud * oversample / clk_freq), kept in 64 bits so the
  // product does not overflow for any sensible width/baud combination.
  function automatic longint unsigned calc_nco_incr(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int unsigned     width
  );
    longint unsigned num;
    num = (64'd1 << width) * baud * oversample;
    return (num + clk_freq / 2) / clk_freq;
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// rtl/uart_baud_nco.sv - phase-accumulator oversample tick generator
// Purpose: adds a fixed increment every clock; the carry-out is a one-cycle tick
//   at BAUD_RATE * OVERSAMPLE on average.
// Ports: clk, rst_n (async active-low), tick (one-cycle pulse, registered).
module uart_baud_nco
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned NCO_WIDTH  = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [NCO_WIDTH-1:0] INCR = NCO_WIDTH'(calc_nco_incr(
    64'(CLK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), NCO_WIDTH));

  logic [NCO_WIDTH-1:0] acc;
  logic [NCO_WIDTH:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, INCR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= sum[NCO_WIDTH-1:0];
      tick <= sum[NCO_WIDTH];
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with error flags and one-entry hold
// Purpose: oversampled receive of DATA_BITS/PARITY/STOP_BITS frames, delivered over
//   a valid/ready handshake; errored frames are delivered with their flags set.
// Ports: clk, rst_n (async active-low); uart_rx serial line (idles high);
//   rdata/rdata_vld/rdata_rdy payload handshake (LSB first bit received);
//   parity_err/frame_err qualify the held payload; overrun_err pulses when a
//   completed frame is dropped because the holding register is full.
// Build option: UART_RX_CFG_MAJORITY_EN selects a 2-of-3 vote around each bit centre.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned NCO_WIDTH  = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter string       PARITY     = "ODD",
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_vld,
  input  logic                 rdata_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam parity_e PAR_MODE = (PARITY == "NONE") ? PAR_NONE :
                                 ((PARITY == "EVEN") ? PAR_EVEN : PAR_ODD);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TCNT_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_RX_CFG_MAJORITY_EN
  localparam logic [TW-1:0] SAMPLE_AT = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] SAMPLE_AT = TW'(OVERSAMPLE / 2 - 1);
`endif

  logic tick;

  uart_baud_nco #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .NCO_WIDTH  (NCO_WIDTH)
  ) u_nco (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  (* ASYNC_REG = "TRUE" *) logic [1:0] rx_sync;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], uart_rx};
  end
  assign rx_s = rx_sync[1];

  logic bit_val;
`ifdef UART_RX_CFG_MAJORITY_EN
  // hist holds the samples from the two ticks before the commit tick
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist <= 2'b11;
    else if (tick) hist <= {hist[0], rx_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  rx_state_e            state, state_n;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [3:0]           bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 pe, pe_n, fe, fe_n;
  logic                 done, done_n;
  // armed: line has been seen high since the last start; blocks repeat frames in a break
  logic                 armed, armed_n;
  logic                 sample, par_exp;

  assign sample  = tick && (tcnt == SAMPLE_AT);
  assign par_exp = (PAR_MODE == PAR_EVEN) ? ^shreg : ~^shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
      pe    <= 1'b0;
      fe    <= 1'b0;
      done  <= 1'b0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      pe    <= pe_n;
      fe    <= fe_n;
      done  <= done_n;
      armed <= armed_n;
    end
  end

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    pe_n    = pe;
    fe_n    = fe;
    done_n  = 1'b0;
    armed_n = armed | rx_s;
    // Free-running wrap keeps every later sample one full bit after the start
    // centre, so passing the start centre is itself the realignment.
    if (tick && (state != ST_IDLE)) tcnt_n = (tcnt == TCNT_MAX) ? '0 : tcnt + TW'(1);
    unique case (state)
      ST_IDLE: begin
        if (tick && !rx_s && armed) begin
          state_n = ST_START;
          tcnt_n  = '0;
          armed_n = 1'b0;
        end
      end
      ST_START: begin
        if (sample) begin
          if (bit_val) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_DATA;
            bcnt_n  = '0;
            pe_n    = 1'b0;
            fe_n    = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_n = {bit_val, shreg[DATA_BITS-1:1]};
          if (bcnt == LAST_DATA) begin
            bcnt_n  = '0;
            state_n = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bcnt_n = bcnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          pe_n    = (bit_val != par_exp);
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          fe_n = fe | ~bit_val;
          if (bcnt == LAST_STOP) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            bcnt_n = bcnt + 4'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rdata_vld   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (done) begin
        if (!rdata_vld || rdata_rdy) begin
          rdata      <= shreg;
          parity_err <= pe;
          frame_err  <= fe;
          rdata_vld  <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rdata_vld && rdata_rdy) begin
        rdata_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg (8O1 and 7E2 instances)
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 320;
  localparam int unsigned TB_CLK  = 32000000;
  localparam int unsigned TB_BAUD = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1;
  logic [7:0] a_rdata;
  logic       a_vld, a_perr, a_ferr, a_ovr;
  logic [6:0] b_rdata;
  logic       b_vld, b_perr, b_ferr, b_ovr;

  int checks = 0;
  int errors = 0;

  logic [10:0] got_a[$];
  logic [10:0] got_b[$];
  int n_vld_a = 0, n_ovr_a = 0, n_ovr_b = 0;

  always #(CLK_NS/2) clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ(TB_CLK), .BAUD_RATE(TB_BAUD), .NCO_WIDTH(16), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_a),
    .rdata(a_rdata), .rdata_vld(a_vld), .rdata_rdy(rdy_a),
    .parity_err(a_perr), .frame_err(a_ferr), .overrun_err(a_ovr)
  );

  uart_rx_cfg #(
    .CLK_FREQ(TB_CLK), .BAUD_RATE(TB_BAUD), .NCO_WIDTH(16), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY("EVEN"), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx_b),
    .rdata(b_rdata), .rdata_vld(b_vld), .rdata_rdy(rdy_b),
    .parity_err(b_perr), .frame_err(b_ferr), .overrun_err(b_ovr)
  );

  // Record every accepted transfer as {frame_err, parity_err, data[8:0]}
  always @(negedge clk) begin
    if (a_vld) n_vld_a++;
    if (a_vld && rdy_a) got_a.push_back({a_ferr, a_perr, 1'b0, a_rdata});
    if (a_ovr) n_ovr_a++;
    if (b_vld && rdy_b) got_b.push_back({b_ferr, b_perr, 2'b00, b_rdata});
    if (b_ovr) n_ovr_b++;
  end

  // Reference rules: parity bit that makes the total count of ones odd/even,
  // and the error a receiver must report for a given data/parity pair.
  function automatic logic good_par(input logic [8:0] d, input bit odd);
    int ones;
    ones = $countones(d);
    return odd ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
  endfunction

  function automatic logic perr_model(input logic [8:0] d, input logic p, input bit odd);
    int ones;
    ones = $countones(d) + int'(p);
    return odd ? logic'(ones % 2 == 0) : logic'(ones % 2 == 1);
  endfunction

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                            input logic p, input logic [1:0] stops, input int nstop);
    set_line(sel, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, d[i]);
      #(BIT_NS);
    end
    set_line(sel, p);
    #(BIT_NS);
    for (int i = 0; i < nstop; i++) begin
      set_line(sel, stops[i]);
      #(BIT_NS);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic clear_mon();
    got_a.delete();
    got_b.delete();
    n_vld_a = 0;
    n_ovr_a = 0;
    n_ovr_b = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({a_vld, a_perr, a_ferr, a_ovr} !== 4'b0000) begin
      $display("FAIL reset_flags got %b exp 0000", {a_vld, a_perr, a_ferr, a_ovr}); errors++;
    end
    checks++;
    if (a_rdata !== 8'h00) begin
      $display("FAIL reset_rdata got %h exp 00", a_rdata); errors++;
    end
    checks++;
    if ({b_vld, b_rdata} !== 8'h00) begin
      $display("FAIL reset_b got %h exp 00", {b_vld, b_rdata}); errors++;
    end
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    checks++;
    if ({a_vld, b_vld, a_ovr, b_ovr} !== 4'b0000) begin
      $display("FAIL post_reset_idle got %b exp 0000", {a_vld, b_vld, a_ovr, b_ovr}); errors++;
    end
  endtask

  task automatic test_8o1_basic();
    logic [10:0] rec;
    clear_mon();
    send_frame(0, 9'h055, 8, 1'b1, 2'b11, 1);
    #(2*BIT_NS);
    rec = (got_a.size() > 0) ? got_a[0] : 11'h7ff;
    checks++;
    if (got_a.size() != 1) begin
      $display("FAIL basic_count got %0d exp 1", got_a.size()); errors++;
    end
    checks++;
    if (rec !== {2'b00, 9'h055}) begin
      $display("FAIL basic_frame got %h exp %h", rec, {2'b00, 9'h055}); errors++;
    end
    checks++;
    if (n_vld_a != 1) begin
      $display("FAIL basic_vld_cycles got %0d exp 1", n_vld_a); errors++;
    end
  endtask

  task automatic test_8o1_random();
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    logic        p;
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      p = good_par({1'b0, d}, 1'b1) ^ ($urandom_range(0, 3) == 0);
      exp_q.push_back({1'b0, perr_model({1'b0, d}, p, 1'b1), 1'b0, d});
      send_frame(0, {1'b0, d}, 8, p, 2'b11, 1);
      #($urandom_range(0, 2) * (BIT_NS/2));
    end
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != exp_q.size()) begin
      $display("FAIL rand8o1_count got %0d exp %0d", got_a.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin
        $display("FAIL rand8o1[%0d] got %h exp %h", i, got_a[i], exp_q[i]); errors++;
      end
    end
  endtask

  task automatic test_7e2_errors();
    logic [10:0] rec;
    clear_mon();
    send_frame(1, 9'h041, 7, ~good_par(9'h041, 1'b0), 2'b11, 2);
    #(2*BIT_NS);
    rec = (got_b.size() > 0) ? got_b[0] : 11'h7ff;
    checks++;
    if (rec !== {1'b0, 1'b1, 9'h041}) begin
      $display("FAIL e7_parity got %h exp %h", rec, {1'b0, 1'b1, 9'h041}); errors++;
    end
    clear_mon();
    send_frame(1, 9'h041, 7, good_par(9'h041, 1'b0), 2'b01, 2);
    #(24*BIT_NS);
    rec = (got_b.size() > 0) ? got_b[0] : 11'h7ff;
    checks++;
    if (rec !== {1'b1, 1'b0, 9'h041}) begin
      $display("FAIL e7_frame got %h exp %h", rec, {1'b1, 1'b0, 9'h041}); errors++;
    end
  endtask

  task automatic test_7e2_random();
    logic [10:0] exp_q[$];
    logic [6:0]  d;
    logic        p;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      d = 7'($urandom_range(0, 127));
      p = good_par({2'b00, d}, 1'b0) ^ ($urandom_range(0, 2) == 0);
      exp_q.push_back({1'b0, perr_model({2'b00, d}, p, 1'b0), 2'b00, d});
      send_frame(1, {2'b00, d}, 7, p, 2'b11, 2);
      #($urandom_range(0, 1) * BIT_NS);
    end
    #(2*BIT_NS);
    checks++;
    if (got_b.size() != exp_q.size()) begin
      $display("FAIL rand7e2_count got %0d exp %0d", got_b.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_q[i]) begin
        $display("FAIL rand7e2[%0d] got %h exp %h", i, got_b[i], exp_q[i]); errors++;
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    @(posedge clk);
    #2;
    rdy_a = 1'b0;
    send_frame(0, 9'h0A5, 8, 1'b1, 2'b11, 1);
    send_frame(0, 9'h03C, 8, 1'b1, 2'b11, 1);
    #(2*BIT_NS);
    checks++;
    if ({a_vld, a_rdata} !== {1'b1, 8'hA5}) begin
      $display("FAIL ovr_hold got %h exp %h", {a_vld, a_rdata}, {1'b1, 8'hA5}); errors++;
    end
    checks++;
    if (n_ovr_a != 1) begin
      $display("FAIL ovr_pulses got %0d exp 1", n_ovr_a); errors++;
    end
    @(posedge clk);
    #2;
    rdy_a = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (a_vld !== 1'b0) begin
      $display("FAIL ovr_vld_drop got %b exp 0", a_vld); errors++;
    end
    checks++;
    if (got_a.size() != 1 || got_a[0] !== {2'b00, 9'h0A5}) begin
      $display("FAIL ovr_accept got %0d entries first %h exp 1 entry %h",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 11'h7ff, {2'b00, 9'h0A5});
      errors++;
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_a = 1'b0;
    #(BIT_NS/4);
    rx_a = 1'b1;
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 0 || a_vld !== 1'b0) begin
      $display("FAIL glitch_no_frame got %0d frames vld %b exp 0 frames", got_a.size(), a_vld);
      errors++;
    end
    send_frame(0, 9'h000, 8, good_par(9'h000, 1'b1), 2'b11, 1);
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== 11'h000) begin
      $display("FAIL glitch_then_00 got %0d entries first %h exp 1 entry 000",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 11'h7ff);
      errors++;
    end
  endtask

  task automatic test_break();
    logic [10:0] exp_brk;
    clear_mon();
    exp_brk = {1'b1, perr_model(9'h000, 1'b0, 1'b1), 9'h000};
    rx_a = 1'b0;
    #(33*BIT_NS);
    rx_a = 1'b1;
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== exp_brk) begin
      $display("FAIL break_frame got %0d entries first %h exp 1 entry %h",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 11'h7ff, exp_brk);
      errors++;
    end
    send_frame(0, 9'h0FF, 8, good_par(9'h0FF, 1'b1), 2'b11, 1);
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 2 || got_a[got_a.size()-1] !== {2'b00, 9'h0FF}) begin
      $display("FAIL break_then_ff got %0d entries last %h exp 2 entries last %h",
               got_a.size(), (got_a.size() > 0) ? got_a[got_a.size()-1] : 11'h7ff,
               {2'b00, 9'h0FF});
      errors++;
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    fork
      send_frame(0, 9'h081, 8, good_par(9'h081, 1'b1), 2'b11, 1);
      begin
        #(4*BIT_NS + BIT_NS/2);
        rst_n = 1'b0;
        #(8*BIT_NS);
        rst_n = 1'b1;
      end
    join
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 0 || a_vld !== 1'b0) begin
      $display("FAIL midreset_no_frame got %0d frames vld %b exp 0", got_a.size(), a_vld);
      errors++;
    end
    send_frame(0, 9'h081, 8, good_par(9'h081, 1'b1), 2'b11, 1);
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== {2'b00, 9'h081}) begin
      $display("FAIL midreset_then_81 got %0d entries first %h exp 1 entry %h",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 11'h7ff, {2'b00, 9'h081});
      errors++;
    end
  endtask

`ifdef UART_RX_CFG_MAJORITY_EN
  task automatic test_majority();
    clear_mon();
    fork
      send_frame(0, 9'h081, 8, good_par(9'h081, 1'b1), 2'b11, 1);
      begin
        #(4*BIT_NS + BIT_NS/2 - CLK_NS/2);
        rx_a = ~rx_a;
        #(CLK_NS);
        rx_a = ~rx_a;
      end
    join
    #(2*BIT_NS);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== {2'b00, 9'h081}) begin
      $display("FAIL majority_81 got %0d entries first %h exp 1 entry %h",
               got_a.size(), (got_a.size() > 0) ? got_a[0] : 11'h7ff, {2'b00, 9'h081});
      errors++;
    end
  endtask
`endif

  initial begin
    test_reset();
    @(posedge clk);
    #2;
    test_8o1_basic();
    test_8o1_random();
    test_7e2_errors();
    test_7e2_random();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_CFG_MAJORITY_EN
    test_majority();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8-bit UART receiver. Supports configurable data width, parity mode (none/odd/even) and stop-bit count. Flags parity, framing and overrun errors per frame, and delivers bytes over a valid/ready handshake with a one-entry holding register. Sits between the board RX pin and the consumer logic (FIFO or command decoder).

Parameters:
- CLK_FREQ, 100000000 — system clock frequency in Hz.
- BAUD_RATE, 115200 — line rate in baud.
- NCO_WIDTH, 16 — phase-accumulator width of the oversample NCO.
- OVERSAMPLE, 16 — ticks per bit; must be even and ≥ 8.
- DATA_BITS, 8 — payload bits per frame; legal range 5..9.
- PARITY, "ODD" — one of "NONE", "ODD", "EVEN".
- STOP_BITS, 1 — 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  asynchronous serial line; idles high.
- rdata  out  DATA_BITS  received payload; LSB is the first bit received.
- rdata_vld  out  1  payload held and valid.
- rdata_rdy  in  1  consumer accepts; transfer occurs when vld && rdy.
- parity_err  out  1  parity mismatch for the held frame; meaningful only while rdata_vld.
- frame_err  out  1  a stop bit was sampled low for the held frame; meaningful only while rdata_vld.
- overrun_err  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. On assertion, all state clears immediately:
  - rdata = 0
  - rdata_vld, parity_err, frame_err, overrun_err = 0
  - FSM goes to IDLE; NCO accumulator = 0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Synchroniser: uart_rx passes through a 2-flop synchroniser (ASYNC_REG) to give rx_s. The same chain resets to all ones.
- Tick generation:
  - NCO_INCR = round(2^NCO_WIDTH * BAUD_RATE * OVERSAMPLE / CLK_FREQ).
  - The accumulator adds NCO_INCR every clk. The carry-out is `tick`, one cycle wide.
- Bit timing: a tick counter tcnt (width $clog2(OVERSAMPLE)) counts ticks within the current bit. A bit is sampled on the tick where tcnt == OVERSAMPLE/2-1 (bit centre).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s == 0, go to START with tcnt = 0.
  - START: at the centre sample:
    - rx_s == 1: glitch; return to IDLE with no output.
    - rx_s == 0: go to DATA and realign tcnt so later samples fall at bit centres; tcnt wraps at OVERSAMPLE-1.
  - DATA: shift in DATA_BITS samples, LSB first. Then go to PARITY if PARITY != "NONE", else to STOP.
  - PARITY: sample one bit. parity_err_next = (sample != expected). Expected is:
    - ODD: ~^data
    - EVEN: ^data
  - STOP: sample STOP_BITS bits. frame_err_next is the OR of the inverted stop samples. On the last stop-bit centre, complete the frame and return to IDLE immediately, allowing back-to-back frames with half-bit resync margin.
- Completion (the clk cycle after the last stop-bit sample):
  - If rdata_vld == 0, or vld && rdy in that same cycle: load rdata, parity_err, frame_err and set rdata_vld = 1.
  - Otherwise drop the new frame, keep the held data unchanged, and pulse overrun_err for one cycle.
- Handshake:
  - rdata_vld stays high until a cycle with rdata_rdy == 1; it clears on the next edge unless a completion loads in the same cycle, in which case vld stays 1 with the new data.
  - rdata, parity_err and frame_err are stable while vld is high.
- Errored frames are still delivered, with their flags set.
- Break condition (line held low): produces a frame with rdata = 0 and frame_err = 1. The FSM then waits in IDLE for rx_s high before accepting a new start, so there are no repeated frames during the break.
- Latency: the last stop-bit centre tick to rdata_vld high is 2 clk.

Optional Feature:
- Macro: UART_RX_CFG_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at the ticks centre-1, centre and centre+1. The START glitch check uses the same vote. The decision timing is unchanged: the sample is committed on the centre+1 tick.
- Undefined: single sample at the centre tick only.

Decomposition:
- Shared package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - FSM state enum.
  - function calc_nco_incr(clk_freq, baud, oversample, width).
- One sub-module, uart_baud_nco: parametrised accumulator emitting `tick`, with asynchronous active-low reset. It is reusable by the future TX block.

Test Plan:
- 8O1, rdy tied high, send 0x55 with correct parity bit 1 → rdata = 0x55, rdata_vld for 1 cycle, parity_err = 0, frame_err = 0.
- 7E2 (DATA_BITS = 7, PARITY = "EVEN", STOP_BITS = 2), send 0x41 with a wrong parity bit → rdata = 0x41, parity_err = 1; then send 0x41 with the second stop bit forced low → frame_err = 1.
- rdy held low, send 0xA5 then 0x3C back-to-back → rdata stays 0xA5, overrun_err pulses once; raise rdy → 0xA5 accepted, vld drops.
- Low glitch of 0.25 bit on an idle line → no frame, FSM returns to IDLE; then a valid 0x00 frame → rdata = 0x00, no errors.
- Line held low for 3 frame times → exactly one frame with rdata = 0, frame_err = 1; after the line returns high, 0xFF is received correctly.
- Deassert rst_n mid-DATA of a 0x81 frame, then release → no rdata_vld; the following 0x81 frame is received cleanly. With UART_RX_CFG_MAJORITY_EN, a single-clock inversion at a bit centre does not corrupt the data.
